// File: rtl/psum_pkg.sv
// Shared definitions for the psum row-done producer and its consumer.
// Holds the FSM encoding, PE row count and row index width.
package psum_pkg;

    localparam int NUM_PE_ROWS = 5;
    localparam int ROW_IDX_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_DONE      = 3'd5
    } psum_state_e;

    function automatic logic [NUM_PE_ROWS-1:0] row_onehot(input logic [ROW_IDX_W-1:0] idx);
        logic [NUM_PE_ROWS-1:0] one;
        one = {{(NUM_PE_ROWS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/psum_row_done_gen_if.sv
// Handshake bundle between the PE rows / Psum_control_unit and psum_row_done_gen.
// master drives strobes, start and ready; slave is the row-done generator.
interface psum_row_done_gen_if
    import psum_pkg::*;
#(
    parameter int PASS_CNT_W = 8
) ();

    logic                   start;
    logic [NUM_PE_ROWS-1:0] mac_valid;
    logic                   ready;
    logic                   row_0_done;
    logic                   row_1_done;
    logic                   row_2_done;
    logic                   row_3_done;
    logic                   row_4_done;
    logic [NUM_PE_ROWS-1:0] row_stall;
    logic [PASS_CNT_W-1:0]  pass_count;
    logic                   layer_done;
    logic                   ack_err;

    modport master (
        output start, mac_valid, ready,
        input  row_0_done, row_1_done, row_2_done, row_3_done, row_4_done,
        input  row_stall, pass_count, layer_done, ack_err
    );

    modport slave (
        input  start, mac_valid, ready,
        output row_0_done, row_1_done, row_2_done, row_3_done, row_4_done,
        output row_stall, pass_count, layer_done, ack_err
    );

endinterface

// File: rtl/psum_row_mac_counter.sv
// Per-row MAC completion counter that saturates at MACS_PER_ROW and flags the row full.
// Clear has priority over a same-cycle strobe, so a strobe on a clearing row is dropped.
module psum_row_mac_counter #(
    parameter int MACS_PER_ROW = 100,
    parameter int MAC_CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_mac_valid,
    output logic o_full
);

    logic [MAC_CNT_W-1:0] r_cnt;
    logic                 w_full;

    assign w_full = (r_cnt == MAC_CNT_W'(MACS_PER_ROW));
    assign o_full = w_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && i_mac_valid && !w_full) begin
            r_cnt <= r_cnt + MAC_CNT_W'(1);
        end
    end

endmodule

// File: rtl/psum_row_done_gen.sv
// Issues row_k_done pulses in strict row order 0..4, one per ready handshake,
// for NUM_PASSES passes per layer, then holds layer_done until the next start.
module psum_row_done_gen
    import psum_pkg::*;
#(
    parameter int MACS_PER_ROW = 100,
    parameter int MAC_CNT_W    = 8,
    parameter int NUM_PASSES   = 229,
    parameter int PASS_CNT_W   = 8,
    parameter int ACK_TIMEOUT  = 4
) (
    input logic               clk,
    input logic               rst,
    psum_row_done_gen_if.slave bus
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    if ((2 ** MAC_CNT_W) <= MACS_PER_ROW) begin : g_chk_mac_w
        $error("MAC_CNT_W is too narrow to hold MACS_PER_ROW");
    end
    if (NUM_PASSES >= (2 ** PASS_CNT_W)) begin : g_chk_pass_w
        $error("NUM_PASSES must be below 2**PASS_CNT_W so pass_count cannot wrap");
    end
    if (ACK_TIMEOUT < 1) begin : g_chk_tmo
        $error("ACK_TIMEOUT must be at least 1");
    end

    psum_state_e            r_state, w_state_nxt;
    logic [ROW_IDX_W-1:0]   r_next_row, w_next_row_nxt;
    logic [PASS_CNT_W-1:0]  r_pass_cnt, w_pass_cnt_nxt, w_pass_inc;
    logic [TMR_W-1:0]       r_ack_tmr, w_ack_tmr_nxt;
    logic                   r_ack_err, w_ack_err_nxt;
    logic [NUM_PE_ROWS-1:0] r_row_done, w_row_done_nxt;
    logic [NUM_PE_ROWS-1:0] w_full;
    logic [NUM_PE_ROWS-1:0] w_clr;
    logic                   w_clr_all;
    logic                   w_clr_issue;
    logic                   w_cnt_en;
    logic                   w_next_full;

    // Counters keep running in every state except DONE, where the layer is frozen.
    assign w_cnt_en    = (r_state != ST_DONE);
    assign w_clr       = {NUM_PE_ROWS{w_clr_all}} |
                         (w_clr_issue ? row_onehot(r_next_row) : {NUM_PE_ROWS{1'b0}});
    assign w_next_full = w_full[r_next_row];
    assign w_pass_inc  = r_pass_cnt + PASS_CNT_W'(1);

    for (genvar k = 0; k < NUM_PE_ROWS; k++) begin : g_row
        psum_row_mac_counter #(
            .MACS_PER_ROW (MACS_PER_ROW),
            .MAC_CNT_W    (MAC_CNT_W)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_clr       (w_clr[k]),
            .i_en        (w_cnt_en),
            .i_mac_valid (bus.mac_valid[k]),
            .o_full      (w_full[k])
        );
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_next_row_nxt = r_next_row;
        w_pass_cnt_nxt = r_pass_cnt;
        w_ack_tmr_nxt  = r_ack_tmr;
        w_ack_err_nxt  = r_ack_err;
        w_row_done_nxt = '0;
        w_clr_all      = 1'b0;
        w_clr_issue    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_clr_all      = 1'b1;
                    w_pass_cnt_nxt = '0;
                    w_next_row_nxt = '0;
                    w_state_nxt    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_next_full && bus.ready) begin
                    w_row_done_nxt = row_onehot(r_next_row);
                    w_state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_clr_issue   = 1'b1;
                w_ack_tmr_nxt = '0;
                w_state_nxt   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!bus.ready) begin
                    w_state_nxt = ST_WAIT_IDLE;
                end else if (r_ack_tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
                    w_ack_err_nxt = 1'b1;
                    w_state_nxt   = ST_WAIT_IDLE;
                end else begin
                    w_ack_tmr_nxt = r_ack_tmr + TMR_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (bus.ready) begin
                    if (r_next_row == ROW_IDX_W'(NUM_PE_ROWS - 1)) begin
                        w_next_row_nxt = '0;
                        w_pass_cnt_nxt = w_pass_inc;
                        w_state_nxt    = (w_pass_inc == PASS_CNT_W'(NUM_PASSES)) ? ST_DONE : ST_RUN;
                    end else begin
                        w_next_row_nxt = r_next_row + ROW_IDX_W'(1);
                        w_state_nxt    = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_next_row <= '0;
            r_pass_cnt <= '0;
            r_ack_tmr  <= '0;
            r_ack_err  <= 1'b0;
            r_row_done <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_next_row <= w_next_row_nxt;
            r_pass_cnt <= w_pass_cnt_nxt;
            r_ack_tmr  <= w_ack_tmr_nxt;
            r_ack_err  <= w_ack_err_nxt;
            r_row_done <= w_row_done_nxt;
        end
    end

    assign bus.row_0_done = r_row_done[0];
    assign bus.row_1_done = r_row_done[1];
    assign bus.row_2_done = r_row_done[2];
    assign bus.row_3_done = r_row_done[3];
    assign bus.row_4_done = r_row_done[4];
    assign bus.row_stall  = w_full;
    assign bus.pass_count = r_pass_cnt;
    assign bus.layer_done = (r_state == ST_DONE);
    assign bus.ack_err    = r_ack_err;

endmodule

// File: tb/tb_psum_row_done_gen.sv
// Bench for psum_row_done_gen: directed scenarios plus a randomized layer run
// checked against a row-level counting model.
module tb_psum_row_done_gen;
    import psum_pkg::*;

    localparam int MACS   = 4;
    localparam int PASSES = 2;
    localparam int TMO    = 4;
    localparam int PCW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    psum_row_done_gen_if #(.PASS_CNT_W(PCW)) bus ();

    psum_row_done_gen #(
        .MACS_PER_ROW (MACS),
        .MAC_CNT_W    (8),
        .NUM_PASSES   (PASSES),
        .PASS_CNT_W   (PCW),
        .ACK_TIMEOUT  (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Row-level model state used by the randomized scenario
    bit       mon_en = 1'b0;
    int       mdl_cnt [5];
    int       mdl_exp_row;
    int       mdl_pulses;
    bit       mdl_saw_low;
    bit       mdl_idle;
    logic [4:0] mon_p;
    logic [4:0] mon_exp_stall;

    function automatic logic [4:0] pulses();
        return {bus.row_4_done, bus.row_3_done, bus.row_2_done, bus.row_1_done, bus.row_0_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.start     = 1'b0;
        bus.mac_valid = '0;
        bus.ready     = 1'b1;
        rst           = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic start_layer();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic strobe(input logic [4:0] m, input int n);
        bus.mac_valid = m;
        repeat (n) tick();
        bus.mac_valid = '0;
    endtask

    // Consumer-style ack: ready drops one cycle after the pulse, rises two cycles later
    task automatic ack_handshake();
        tick();
        bus.ready = 1'b0;
        repeat (2) tick();
        bus.ready = 1'b1;
        tick();
    endtask

    task automatic wait_pulse(input int budget, output int row);
        logic [4:0] p;
        bit found;
        row = -1;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            p = pulses();
            if (p != 0) begin
                found = 1'b1;
                for (int k = 0; k < 5; k++) if (p[k]) row = k;
            end
        end
    endtask

    // Model: per-row strobe counts, clears on start/pulse, frozen while layer_done
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon_p = pulses();
                for (int k = 0; k < 5; k++) mon_exp_stall[k] = (mdl_cnt[k] == MACS);
                checks++;
                if (bus.row_stall !== mon_exp_stall) begin
                    errors++;
                    $display("FAIL rnd_row_stall: got %b expected %b", bus.row_stall, mon_exp_stall);
                end
                if (mon_p != 0) begin
                    checks++;
                    if (mon_p !== (5'(1) << mdl_exp_row) || mdl_cnt[mdl_exp_row] != MACS ||
                        (mdl_pulses > 0 && !mdl_saw_low)) begin
                        errors++;
                        $display("FAIL rnd_pulse: got %b expected row %0d (cnt %0d, ready_low_seen %0d)",
                                 mon_p, mdl_exp_row, mdl_cnt[mdl_exp_row], mdl_saw_low);
                    end
                    mdl_exp_row = (mdl_exp_row + 1) % 5;
                    mdl_pulses++;
                    mdl_saw_low = 1'b0;
                end
                if (!bus.ready) mdl_saw_low = 1'b1;
                if (bus.start && (mdl_idle || bus.layer_done)) begin
                    for (int k = 0; k < 5; k++) mdl_cnt[k] = 0;
                    mdl_idle = 1'b0;
                end else begin
                    for (int k = 0; k < 5; k++) begin
                        if (mon_p[k]) mdl_cnt[k] = 0;
                        else if (!bus.layer_done && bus.mac_valid[k] && mdl_cnt[k] < MACS) mdl_cnt[k]++;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [4:0] seen;
        do_reset();
        checks++;
        if (pulses() !== 5'b0 || bus.row_stall !== 5'b0 || bus.pass_count !== '0 ||
            bus.layer_done !== 1'b0 || bus.ack_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pulses=%b stall=%b pass=%0d layer=%b err=%b expected all 0",
                     pulses(), bus.row_stall, bus.pass_count, bus.layer_done, bus.ack_err);
        end
        start_layer();
        strobe(5'b00001, MACS);
        tick();
        checks++;
        if (bus.row_0_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_issue: got row_0_done=%b expected 1", bus.row_0_done);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.row_0_done !== 1'b0 || bus.row_stall !== 5'b0 || bus.pass_count !== '0) begin
            errors++;
            $display("FAIL reset_async: got row_0_done=%b stall=%b pass=%0d expected 0/0/0",
                     bus.row_0_done, bus.row_stall, bus.pass_count);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        bus.ready = 1'b1;
        bus.mac_valid = 5'b00001;
        seen = '0;
        repeat (8) begin
            tick();
            seen |= pulses();
        end
        bus.mac_valid = '0;
        checks++;
        if (seen !== 5'b0) begin
            errors++;
            $display("FAIL reset_idle_no_pulse: got %b expected 00000", seen);
        end
        start_layer();
        checks++;
        if (bus.row_stall !== 5'b0) begin
            errors++;
            $display("FAIL start_clears: got stall=%b expected 00000", bus.row_stall);
        end
    endtask

    task automatic test_basic();
        int row;
        do_reset();
        start_layer();
        bus.ready = 1'b1;
        strobe(5'b00001, MACS - 1);
        checks++;
        if (bus.row_stall !== 5'b0) begin
            errors++;
            $display("FAIL basic_not_full: got stall=%b expected 00000", bus.row_stall);
        end
        strobe(5'b00001, 1);
        checks++;
        if (bus.row_stall !== 5'b00001 || pulses() !== 5'b0) begin
            errors++;
            $display("FAIL basic_full: got stall=%b pulses=%b expected 00001/00000", bus.row_stall, pulses());
        end
        tick();
        checks++;
        if (pulses() !== 5'b00001) begin
            errors++;
            $display("FAIL basic_pulse: got %b expected 00001", pulses());
        end
        bus.mac_valid = 5'b00011;
        bus.ready = 1'b0;
        tick();
        bus.mac_valid = '0;
        checks++;
        if (pulses() !== 5'b0 || bus.row_stall !== 5'b0) begin
            errors++;
            $display("FAIL basic_after_issue: got pulses=%b stall=%b expected 00000/00000", pulses(), bus.row_stall);
        end
        strobe(5'b00011, MACS - 1);
        checks++;
        if (bus.row_stall !== 5'b00010) begin
            errors++;
            $display("FAIL basic_issue_drop: got stall=%b expected 00010", bus.row_stall);
        end
        strobe(5'b00001, 1);
        checks++;
        if (bus.row_stall !== 5'b00011) begin
            errors++;
            $display("FAIL basic_refill: got stall=%b expected 00011", bus.row_stall);
        end
        bus.ready = 1'b1;
        wait_pulse(4, row);
        checks++;
        if (row != 1) begin
            errors++;
            $display("FAIL basic_next_row: got row %0d expected 1", row);
        end
    endtask

    task automatic test_out_of_order();
        logic [4:0] seen;
        int row;
        do_reset();
        start_layer();
        bus.ready = 1'b1;
        strobe(5'b00100, MACS);
        seen = '0;
        repeat (4) begin
            tick();
            seen |= pulses();
        end
        checks++;
        if (seen !== 5'b0 || bus.row_stall !== 5'b00100) begin
            errors++;
            $display("FAIL ooo_wait_row0: got pulses=%b stall=%b expected 00000/00100", seen, bus.row_stall);
        end
        strobe(5'b00001, MACS);
        tick();
        checks++;
        if (pulses() !== 5'b00001) begin
            errors++;
            $display("FAIL ooo_row0_pulse: got %b expected 00001", pulses());
        end
        tick();
        bus.ready = 1'b0;
        bus.mac_valid = 5'b00010;
        seen = '0;
        repeat (MACS + 2) begin
            tick();
            seen |= pulses();
            if (bus.row_stall[1]) bus.mac_valid = '0;
        end
        bus.mac_valid = '0;
        checks++;
        if (seen !== 5'b0 || bus.row_stall !== 5'b00110) begin
            errors++;
            $display("FAIL ooo_hold_ready_low: got pulses=%b stall=%b expected 00000/00110", seen, bus.row_stall);
        end
        bus.ready = 1'b1;
        wait_pulse(4, row);
        checks++;
        if (row != 1) begin
            errors++;
            $display("FAIL ooo_row1: got row %0d expected 1", row);
        end
        ack_handshake();
        wait_pulse(3, row);
        checks++;
        if (row != 2) begin
            errors++;
            $display("FAIL ooo_row2: got row %0d expected 2", row);
        end
        ack_handshake();
    endtask

    task automatic test_overflow();
        int row;
        do_reset();
        start_layer();
        bus.ready = 1'b1;
        strobe(5'b00010, MACS + 2);
        checks++;
        if (bus.row_stall !== 5'b00010 || pulses() !== 5'b0) begin
            errors++;
            $display("FAIL ovf_stall: got stall=%b pulses=%b expected 00010/00000", bus.row_stall, pulses());
        end
        strobe(5'b00001, MACS);
        wait_pulse(3, row);
        checks++;
        if (row != 0) begin
            errors++;
            $display("FAIL ovf_row0: got row %0d expected 0", row);
        end
        ack_handshake();
        wait_pulse(3, row);
        checks++;
        if (row != 1 || bus.row_stall[1] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_row1: got row %0d stall1=%b expected 1/1", row, bus.row_stall[1]);
        end
        ack_handshake();
        checks++;
        if (bus.row_stall !== 5'b0) begin
            errors++;
            $display("FAIL ovf_cleared: got stall=%b expected 00000", bus.row_stall);
        end
        strobe(5'b00010, MACS - 1);
        checks++;
        if (bus.row_stall !== 5'b0) begin
            errors++;
            $display("FAIL ovf_recount: got stall=%b expected 00000", bus.row_stall);
        end
        strobe(5'b00010, 1);
        checks++;
        if (bus.row_stall !== 5'b00010) begin
            errors++;
            $display("FAIL ovf_refull: got stall=%b expected 00010", bus.row_stall);
        end
    endtask

    task automatic test_full_layer();
        int row;
        do_reset();
        start_layer();
        bus.ready = 1'b1;
        for (int p = 0; p < PASSES; p++) begin
            for (int k = 0; k < 5; k++) begin
                strobe(5'(1) << k, MACS);
                wait_pulse(3, row);
                checks++;
                if (row != k) begin
                    errors++;
                    $display("FAIL layer_order: pass %0d got row %0d expected %0d", p, row, k);
                end
                ack_handshake();
            end
            checks++;
            if (bus.pass_count !== PCW'(p + 1)) begin
                errors++;
                $display("FAIL layer_pass_count: got %0d expected %0d", bus.pass_count, p + 1);
            end
        end
        checks++;
        if (bus.layer_done !== 1'b1) begin
            errors++;
            $display("FAIL layer_done: got %b expected 1", bus.layer_done);
        end
        strobe(5'b11111, MACS + 1);
        checks++;
        if (bus.row_stall !== 5'b0 || bus.pass_count !== PCW'(PASSES) || bus.layer_done !== 1'b1) begin
            errors++;
            $display("FAIL layer_frozen: got stall=%b pass=%0d layer=%b expected 00000/%0d/1",
                     bus.row_stall, bus.pass_count, bus.layer_done, PASSES);
        end
        start_layer();
        checks++;
        if (bus.layer_done !== 1'b0 || bus.pass_count !== '0) begin
            errors++;
            $display("FAIL layer_restart: got layer=%b pass=%0d expected 0/0", bus.layer_done, bus.pass_count);
        end
        strobe(5'b00001, MACS);
        checks++;
        if (bus.row_stall !== 5'b00001) begin
            errors++;
            $display("FAIL layer_recount: got stall=%b expected 00001", bus.row_stall);
        end
    endtask

    task automatic test_ack_timeout();
        int row;
        do_reset();
        start_layer();
        bus.ready = 1'b1;
        strobe(5'b00011, MACS);
        tick();
        checks++;
        if (pulses() !== 5'b00001 || bus.ack_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse: got pulses=%b ack_err=%b expected 00001/0", pulses(), bus.ack_err);
        end
        repeat (TMO) tick();
        checks++;
        if (bus.ack_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early: got ack_err=%b expected 0", bus.ack_err);
        end
        tick();
        checks++;
        if (bus.ack_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_set: got ack_err=%b expected 1", bus.ack_err);
        end
        wait_pulse(4, row);
        checks++;
        if (row != 1) begin
            errors++;
            $display("FAIL tmo_continue: got row %0d expected 1", row);
        end
        ack_handshake();
        checks++;
        if (bus.ack_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: got ack_err=%b expected 1", bus.ack_err);
        end
    endtask

    task automatic test_random();
        logic [4:0] p;
        bit drop_pending;
        int low_left;
        int cyc;
        do_reset();
        for (int k = 0; k < 5; k++) mdl_cnt[k] = 0;
        mdl_exp_row  = 0;
        mdl_pulses   = 0;
        mdl_saw_low  = 1'b0;
        mdl_idle     = 1'b1;
        mon_en       = 1'b1;
        bus.ready    = 1'b1;
        drop_pending = 1'b0;
        low_left     = 0;
        bus.mac_valid = 5'($urandom_range(0, 31));
        start_layer();
        cyc = 0;
        while (cyc < 3000 && bus.layer_done !== 1'b1) begin
            tick();
            cyc++;
            p = pulses();
            if (p != 0) begin
                drop_pending = 1'b1;
            end else if (drop_pending) begin
                bus.ready = 1'b0;
                low_left = $urandom_range(1, 6);
                drop_pending = 1'b0;
            end else if (!bus.ready) begin
                low_left--;
                if (low_left <= 0) bus.ready = 1'b1;
            end
            bus.mac_valid = 5'($urandom_range(0, 31));
        end
        checks++;
        if (bus.layer_done !== 1'b1 || mdl_pulses != 5 * PASSES || bus.pass_count !== PCW'(PASSES) ||
            bus.ack_err !== 1'b0) begin
            errors++;
            $display("FAIL rnd_layer: got layer=%b pulses=%0d pass=%0d err=%b expected 1/%0d/%0d/0",
                     bus.layer_done, mdl_pulses, bus.pass_count, bus.ack_err, 5 * PASSES, PASSES);
        end
        repeat (6) begin
            bus.mac_valid = 5'($urandom_range(0, 31));
            tick();
        end
        bus.mac_valid = 5'($urandom_range(0, 31));
        start_layer();
        checks++;
        if (bus.layer_done !== 1'b0 || bus.pass_count !== '0) begin
            errors++;
            $display("FAIL rnd_restart: got layer=%b pass=%0d expected 0/0", bus.layer_done, bus.pass_count);
        end
        repeat (6) begin
            bus.mac_valid = 5'($urandom_range(0, 31));
            tick();
        end
        bus.mac_valid = '0;
        @(negedge clk);
        mon_en = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.mac_valid = '0;
        bus.ready     = 1'b1;
        test_reset();
        test_basic();
        test_out_of_order();
        test_overflow();
        test_full_layer();
        test_ack_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (checks %0d, errors %0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
